axi_pmu_v2: RTL and testbench
=============================

# axi_pmu_v2

Parametrised AXI performance monitoring unit that passively observes one AXI4 master/slave link via a monitor modport. It counts stall, handshake, idle and occupancy events per channel with saturating counters. Software-visible snapshot and clear controls are provided, and compile-time optional latency accumulators are included. One instance sits beside each monitored AXI port; a CSR bridge reads it through a registered address/data port.

## Interface
- `CNT_W`, default 48: event counter width, 16..64; zero-extended to 64 on `data_o`.
- `OCC_W`, default 8: width of the read/write outstanding and responding occupancy trackers.
- `aclk`, input, 1: clock.
- `aresetn`, input, 1: reset, asynchronous, active-low. Clock is `aclk`.
- `mon_axi`, `axi_if.mon`: monitored AXI link; all inputs, never driven.
- `enable_i`, input, 1: event counters increment only while high. Occupancy trackers always run.
- `clear_i`, input, 1: one-cycle pulse; zeroes all event counters, max registers and sticky flags.
- `snap_i`, input, 1: one-cycle pulse; copies every live counter into the shadow bank.
- `addr_i`, input, 5: shadow bank select.
- `data_o`, output, 64: registered shadow value at `addr_i`.
- `overflow_o`, output, 1: sticky; set when any event counter reaches all-ones.
- `proto_err_o`, output, 1: sticky; set on an occupancy underflow or overflow attempt.

## Operation
- **Occupancy trackers**
  - `rd_out`: +1 on AR handshake; −1 on R handshake with RLAST; both in the same cycle means no change.
  - `wr_out`: +1 on AW handshake; −1 on B handshake.
  - `wr_resp`: +1 on W handshake with WLAST; −1 on B handshake (BVALID && BREADY).
  - A decrement at 0 or an increment at all-ones holds the value and sets `proto_err_o`.
- **Event counters** (increment when `enable_i` is high and the condition holds that cycle):
  - `rd_idle`: !ARVALID && `rd_out`==0.
  - `ar_stall`: ARVALID && !ARREADY.
  - `ar_hs`: AR handshake.
  - `rvalid_stall`: `rd_out`!=0 && !RVALID.
  - `rready_stall`: RVALID && !RREADY.
  - `r_hs`: R handshake.
  - The write side mirrors the read side: `wr_idle`, `aw_stall`, `aw_hs`, `w_hs`, `wready_stall` (WVALID && !WREADY), `b_hs`, `bready_stall` (BVALID && !BREADY).
  - `wvalid_stall`: `wr_out` > `wr_resp` && !WVALID.
  - `bvalid_stall`: `wr_resp`!=0 && !BVALID.
  - `cycles`: every enabled cycle.
- **Saturation:** every event counter saturates at 2^CNT_W−1 and never wraps. Reaching saturation sets `overflow_o`.
- **Max registers:** `rd_max` and `wr_max` track the peak of `rd_out` and `wr_out` respectively.
- **Shadow address map:**
  - 0 `rd_idle`, 1 `rd_out`, 2 `ar_stall`, 3 `ar_hs`, 4 `rvalid_stall`, 5 `rready_stall`, 6 `r_hs`
  - 7 `wr_idle`, 8 `wr_out`, 9 `wr_resp`, 10 `aw_stall`, 11 `aw_hs`, 12 `wvalid_stall`, 13 `wready_stall`, 14 `w_hs`
  - 15 `bvalid_stall`, 16 `bready_stall`, 17 `b_hs`, 18 `cycles`
  - 19 `rd_lat_sum`, 20 `wr_lat_sum`, 21 `rd_max`, 22 `wr_max`
  - 23 status {proto_err, overflow, enable_i}
  - 24..31 read 0
- **Simultaneous `snap_i` and `clear_i`:** the shadow captures the pre-clear values, then the live counters become 0.

## Timing
- **Reset:** all counters, trackers, shadow bank, `data_o`, `overflow_o` and `proto_err_o` are 0.
- **Counter update:** a counter updates on the edge that ends the cycle in which its condition is sampled.
- **Snapshot:** a `snap_i` asserted in cycle N captures the counter values as updated at the end of cycle N−1. The shadow is visible from N+1.
- **Read latency:** `data_o` reflects `addr_i` sampled one cycle earlier.
- **Clear:** `clear_i` in cycle N forces the affected registers to 0 at the end of N; events in cycle N are discarded.
- **Mid-burst reset:** trackers restart at 0, and in-flight responses set `proto_err_o` after reset. This is accepted behaviour.

## Configuration
- `AXI_PMU_LATENCY_EN` defined:
  - `rd_lat_sum` adds `rd_out` every enabled cycle.
  - `wr_lat_sum` adds `wr_out` every enabled cycle.
  - Both are CNT_W wide and saturating, so total latency = sum; average = sum / handshakes.
  - `rd_max` and `wr_max` are active.
- `AXI_PMU_LATENCY_EN` undefined: addresses 19–22 read 0 and the logic is not synthesised.

## Test plan
- **Reset and idle:** release reset, hold all VALIDs low with `enable_i`=1 for 10 cycles, then snap and read. Expected: addresses 0, 7 and 18 read 10; all others 0.
- **Read pipelining:**
  - Stimulus: 3 AR handshakes back-to-back; the slave returns 3 bursts of 4 beats, with RVALID gaps of 2 cycles before each.
  - Expected: `ar_hs`=3, `r_hs`=12, `rvalid_stall` ≥ 6, `rd_max`=3, `rd_out`=0 after the last RLAST.
- **Write, W before AW:** WLAST is accepted before AWVALID; AW arrives 2 cycles later; B follows after 3 cycles, with BREADY low for 1 cycle. Expected: `w_hs`=1, `aw_hs`=1, `bready_stall`=1, `b_hs`=1, `wr_resp`=0, `proto_err_o`=0.
- **Saturation:** with CNT_W=16, keep ARVALID high and ARREADY low for 70000 cycles. Expected: `ar_stall`=65535 and `overflow_o`=1. A subsequent `clear_i` gives 0 and `overflow_o`=0.
- **Snap plus clear:** assert `snap_i` and `clear_i` in the same cycle when `cycles`=100. Expected: address 18 reads 100; the next snap 5 cycles later reads 5.
- **Protocol error:** inject an R beat with RLAST while `rd_out`=0. Expected: `rd_out` stays 0 and `proto_err_o`=1.

Source files
------------

// File: rtl/axi_pmu_v2_if.sv
// rtl/axi_pmu_v2_if.sv - AXI4 handshake and last-beat signals observed by the PMU
interface axi_if;
   logic arvalid;
   logic arready;
   logic rvalid;
   logic rready;
   logic rlast;
   logic awvalid;
   logic awready;
   logic wvalid;
   logic wready;
   logic wlast;
   logic bvalid;
   logic bready;

   modport mon (
      input arvalid, arready, rvalid, rready, rlast,
      input awvalid, awready, wvalid, wready, wlast, bvalid, bready
   );

   modport master (
      output arvalid, rready, awvalid, wvalid, wlast, bready,
      input  arready, rvalid, rlast, awready, wready, bvalid
   );

   modport slave (
      input  arvalid, rready, awvalid, wvalid, wlast, bready,
      output arready, rvalid, rlast, awready, wready, bvalid
   );
endinterface

// File: rtl/axi_pmu_v2.sv
// rtl/axi_pmu_v2.sv - AXI performance monitor: occupancy trackers, saturating event counters, shadow bank
// Latency accumulators and peak registers are built only when AXI_PMU_LATENCY_EN is defined.
module axi_pmu_v2 #(
   parameter int CNT_W = 48,
   parameter int OCC_W = 8
) (
   input  logic        aclk,
   input  logic        aresetn,
   axi_if.mon          mon_axi,
   input  logic        enable_i,
   input  logic        clear_i,
   input  logic        snap_i,
   input  logic [4:0]  addr_i,
   output logic [63:0] data_o,
   output logic        overflow_o,
   output logic        proto_err_o
);
   localparam int N_EVT = 16;
   localparam int N_SHD = 24;
   localparam int SUM_W = CNT_W + 1;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;
   localparam logic [CNT_W-1:0] CNT_PRE = CNT_MAX - CNT_W'(1);
   localparam logic [OCC_W-1:0] OCC_MAX = '1;

   localparam int E_RD_IDLE      = 0;
   localparam int E_AR_STALL     = 1;
   localparam int E_AR_HS        = 2;
   localparam int E_RVALID_STALL = 3;
   localparam int E_RREADY_STALL = 4;
   localparam int E_R_HS         = 5;
   localparam int E_WR_IDLE      = 6;
   localparam int E_AW_STALL     = 7;
   localparam int E_AW_HS        = 8;
   localparam int E_WVALID_STALL = 9;
   localparam int E_WREADY_STALL = 10;
   localparam int E_W_HS         = 11;
   localparam int E_BVALID_STALL = 12;
   localparam int E_BREADY_STALL = 13;
   localparam int E_B_HS         = 14;
   localparam int E_CYCLES       = 15;

   logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
   assign ar_hs = mon_axi.arvalid & mon_axi.arready;
   assign r_hs  = mon_axi.rvalid  & mon_axi.rready;
   assign aw_hs = mon_axi.awvalid & mon_axi.awready;
   assign w_hs  = mon_axi.wvalid  & mon_axi.wready;
   assign b_hs  = mon_axi.bvalid  & mon_axi.bready;

   // Returns {error, next}; an illegal step holds the value and flags the error.
   function automatic logic [OCC_W:0] occ_step(input logic [OCC_W-1:0] cur,
                                               input logic inc, input logic dec);
      logic [OCC_W:0] r;
      r = {1'b0, cur};
      if (inc && !dec) begin
         if (cur == OCC_MAX) r[OCC_W] = 1'b1;
         else                r = {1'b0, cur + OCC_W'(1)};
      end else if (dec && !inc) begin
         if (cur == '0) r[OCC_W] = 1'b1;
         else           r = {1'b0, cur - OCC_W'(1)};
      end
      return r;
   endfunction

   logic [OCC_W-1:0] rd_out, wr_out, wr_resp;
   logic [OCC_W-1:0] rd_out_nxt, wr_out_nxt, wr_resp_nxt;
   logic             rd_err, wr_err, resp_err;

   assign {rd_err, rd_out_nxt}    = occ_step(rd_out, ar_hs, r_hs & mon_axi.rlast);
   assign {wr_err, wr_out_nxt}    = occ_step(wr_out, aw_hs, b_hs);
   assign {resp_err, wr_resp_nxt} = occ_step(wr_resp, w_hs & mon_axi.wlast, b_hs);

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         rd_out  <= '0;
         wr_out  <= '0;
         wr_resp <= '0;
      end else begin
         rd_out  <= rd_out_nxt;
         wr_out  <= wr_out_nxt;
         wr_resp <= wr_resp_nxt;
      end
   end

   logic [N_EVT-1:0] evt;
   always_comb begin
      evt = '0;
      evt[E_RD_IDLE]      = !mon_axi.arvalid && (rd_out == '0);
      evt[E_AR_STALL]     = mon_axi.arvalid && !mon_axi.arready;
      evt[E_AR_HS]        = ar_hs;
      evt[E_RVALID_STALL] = (rd_out != '0) && !mon_axi.rvalid;
      evt[E_RREADY_STALL] = mon_axi.rvalid && !mon_axi.rready;
      evt[E_R_HS]         = r_hs;
      evt[E_WR_IDLE]      = !mon_axi.awvalid && (wr_out == '0);
      evt[E_AW_STALL]     = mon_axi.awvalid && !mon_axi.awready;
      evt[E_AW_HS]        = aw_hs;
      evt[E_WVALID_STALL] = (wr_out > wr_resp) && !mon_axi.wvalid;
      evt[E_WREADY_STALL] = mon_axi.wvalid && !mon_axi.wready;
      evt[E_W_HS]         = w_hs;
      evt[E_BVALID_STALL] = (wr_resp != '0) && !mon_axi.bvalid;
      evt[E_BREADY_STALL] = mon_axi.bvalid && !mon_axi.bready;
      evt[E_B_HS]         = b_hs;
      evt[E_CYCLES]       = 1'b1;
   end

   logic [CNT_W-1:0] cnt [N_EVT];
   logic             cnt_hit;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         for (int i = 0; i < N_EVT; i++) cnt[i] <= '0;
      end else if (clear_i) begin
         for (int i = 0; i < N_EVT; i++) cnt[i] <= '0;
      end else if (enable_i) begin
         for (int i = 0; i < N_EVT; i++)
            if (evt[i] && (cnt[i] != CNT_MAX)) cnt[i] <= cnt[i] + CNT_W'(1);
      end
   end

   // Overflow is flagged on the increment that lands on all-ones.
   always_comb begin
      cnt_hit = 1'b0;
      for (int i = 0; i < N_EVT; i++)
         if (enable_i && evt[i] && (cnt[i] == CNT_PRE)) cnt_hit = 1'b1;
   end

   logic        lat_hit;
   logic [63:0] rd_lat_val, wr_lat_val, rd_max_val, wr_max_val;

`ifdef AXI_PMU_LATENCY_EN
   logic [CNT_W-1:0] rd_lat_sum, wr_lat_sum, rd_lat_nxt, wr_lat_nxt;
   logic [SUM_W-1:0] rd_lat_add, wr_lat_add;
   logic [OCC_W-1:0] rd_max, wr_max;

   assign rd_lat_add = {1'b0, rd_lat_sum} + SUM_W'(rd_out);
   assign wr_lat_add = {1'b0, wr_lat_sum} + SUM_W'(wr_out);
   assign rd_lat_nxt = rd_lat_add[CNT_W] ? CNT_MAX : rd_lat_add[CNT_W-1:0];
   assign wr_lat_nxt = wr_lat_add[CNT_W] ? CNT_MAX : wr_lat_add[CNT_W-1:0];

   assign lat_hit = enable_i &&
                    (((rd_lat_sum != CNT_MAX) && (rd_lat_nxt == CNT_MAX)) ||
                     ((wr_lat_sum != CNT_MAX) && (wr_lat_nxt == CNT_MAX)));

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         rd_lat_sum <= '0;
         wr_lat_sum <= '0;
         rd_max     <= '0;
         wr_max     <= '0;
      end else if (clear_i) begin
         rd_lat_sum <= '0;
         wr_lat_sum <= '0;
         rd_max     <= '0;
         wr_max     <= '0;
      end else begin
         if (enable_i) begin
            rd_lat_sum <= rd_lat_nxt;
            wr_lat_sum <= wr_lat_nxt;
         end
         if (rd_out_nxt > rd_max) rd_max <= rd_out_nxt;
         if (wr_out_nxt > wr_max) wr_max <= wr_out_nxt;
      end
   end

   assign rd_lat_val = 64'(rd_lat_sum);
   assign wr_lat_val = 64'(wr_lat_sum);
   assign rd_max_val = 64'(rd_max);
   assign wr_max_val = 64'(wr_max);
`else
   assign lat_hit    = 1'b0;
   assign rd_lat_val = '0;
   assign wr_lat_val = '0;
   assign rd_max_val = '0;
   assign wr_max_val = '0;
`endif

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         overflow_o  <= 1'b0;
         proto_err_o <= 1'b0;
      end else if (clear_i) begin
         overflow_o  <= 1'b0;
         proto_err_o <= 1'b0;
      end else begin
         if (cnt_hit || lat_hit)          overflow_o  <= 1'b1;
         if (rd_err || wr_err || resp_err) proto_err_o <= 1'b1;
      end
   end

   logic [63:0] live [N_SHD];
   always_comb begin
      live[0]  = 64'(cnt[E_RD_IDLE]);
      live[1]  = 64'(rd_out);
      live[2]  = 64'(cnt[E_AR_STALL]);
      live[3]  = 64'(cnt[E_AR_HS]);
      live[4]  = 64'(cnt[E_RVALID_STALL]);
      live[5]  = 64'(cnt[E_RREADY_STALL]);
      live[6]  = 64'(cnt[E_R_HS]);
      live[7]  = 64'(cnt[E_WR_IDLE]);
      live[8]  = 64'(wr_out);
      live[9]  = 64'(wr_resp);
      live[10] = 64'(cnt[E_AW_STALL]);
      live[11] = 64'(cnt[E_AW_HS]);
      live[12] = 64'(cnt[E_WVALID_STALL]);
      live[13] = 64'(cnt[E_WREADY_STALL]);
      live[14] = 64'(cnt[E_W_HS]);
      live[15] = 64'(cnt[E_BVALID_STALL]);
      live[16] = 64'(cnt[E_BREADY_STALL]);
      live[17] = 64'(cnt[E_B_HS]);
      live[18] = 64'(cnt[E_CYCLES]);
      live[19] = rd_lat_val;
      live[20] = wr_lat_val;
      live[21] = rd_max_val;
      live[22] = wr_max_val;
      live[23] = {61'd0, proto_err_o, overflow_o, enable_i};
   end

   // Shadow copies the registered values, so a simultaneous clear still leaves pre-clear data.
   logic [63:0] shadow [N_SHD];
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         for (int i = 0; i < N_SHD; i++) shadow[i] <= '0;
      end else if (snap_i) begin
         for (int i = 0; i < N_SHD; i++) shadow[i] <= live[i];
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn)               data_o <= '0;
      else if (addr_i <= 5'd23)   data_o <= shadow[addr_i];
      else                        data_o <= '0;
   end
endmodule

// File: tb/tb_axi_pmu_v2.sv
// tb/tb_axi_pmu_v2.sv - scoreboard bench for axi_pmu_v2 built with CNT_W=16
module tb_axi_pmu_v2;
   logic        aclk = 1'b0;
   logic        aresetn;
   logic        enable_i, clear_i, snap_i;
   logic [4:0]  addr_i;
   logic [63:0] data_o;
   logic        overflow_o, proto_err_o;

   axi_if bus();

   axi_pmu_v2 #(.CNT_W(16), .OCC_W(8)) dut (
      .aclk        (aclk),
      .aresetn     (aresetn),
      .mon_axi     (bus),
      .enable_i    (enable_i),
      .clear_i     (clear_i),
      .snap_i      (snap_i),
      .addr_i      (addr_i),
      .data_o      (data_o),
      .overflow_o  (overflow_o),
      .proto_err_o (proto_err_o)
   );

   always #5 aclk = ~aclk;

`ifdef AXI_PMU_LATENCY_EN
   localparam logic [63:0] EXP_RD_LAT = 64'd39;
   localparam logic [63:0] EXP_RD_MAX = 64'd3;
   localparam logic [63:0] EXP_WR_LAT = 64'd4;
   localparam logic [63:0] EXP_WR_MAX = 64'd1;
`else
   localparam logic [63:0] EXP_RD_LAT = 64'd0;
   localparam logic [63:0] EXP_RD_MAX = 64'd0;
   localparam logic [63:0] EXP_WR_LAT = 64'd0;
   localparam logic [63:0] EXP_WR_MAX = 64'd0;
`endif

   int n_vec = 0;
   int n_err = 0;

   logic [63:0] exp_q [$];
   string       tag_q [$];
   logic        rd_req = 1'b0;
   logic        rd_v   = 1'b0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   always @(posedge aclk) rd_v <= rd_req;

   always @(negedge aclk) begin
      if (rd_v) begin
         if (exp_q.size() == 0) chk("q_underrun", 64'(exp_q.size()), 64'd1);
         else chk(tag_q.pop_front(), data_o, exp_q.pop_front());
      end
   end

   task automatic rd(input int a, input logic [63:0] exp, input string tag);
      addr_i = 5'(a);
      rd_req = 1'b1;
      exp_q.push_back(exp);
      tag_q.push_back(tag);
      @(negedge aclk);
      rd_req = 1'b0;
   endtask

   task automatic do_snap();
      snap_i = 1'b1;
      @(negedge aclk);
      snap_i = 1'b0;
   endtask

   task automatic do_clear();
      clear_i = 1'b1;
      @(negedge aclk);
      clear_i = 1'b0;
   endtask

   initial begin
      aresetn = 1'b0; enable_i = 1'b0; clear_i = 1'b0; snap_i = 1'b0; addr_i = '0;
      bus.arvalid = 0; bus.arready = 0; bus.rvalid = 0; bus.rready = 0; bus.rlast = 0;
      bus.awvalid = 0; bus.awready = 0; bus.wvalid = 0; bus.wready = 0; bus.wlast = 0;
      bus.bvalid = 0; bus.bready = 0;
      repeat (3) @(negedge aclk);
      chk("rst_data", data_o, 64'd0);
      chk("rst_ovf", 64'(overflow_o), 64'd0);
      chk("rst_perr", 64'(proto_err_o), 64'd0);

      // reset and idle
      aresetn = 1'b1; enable_i = 1'b1;
      repeat (10) @(negedge aclk);
      enable_i = 1'b0;
      do_snap();
      for (int a = 0; a < 24; a++)
         rd(a, (a == 0 || a == 7 || a == 18) ? 64'd10 : 64'd0, $sformatf("idle_a%0d", a));
      rd(24, 64'd0, "idle_a24");
      rd(31, 64'd0, "idle_a31");

      // read pipelining: 3 ARs, 3 bursts of 4 beats, 2-cycle RVALID gap before each
      do_clear();
      enable_i = 1'b1; bus.rready = 1'b1;
      bus.arvalid = 1'b1; bus.arready = 1'b1;
      repeat (3) @(negedge aclk);
      bus.arvalid = 1'b0; bus.arready = 1'b0;
      for (int b = 0; b < 3; b++) begin
         bus.rvalid = 1'b0; bus.rlast = 1'b0;
         repeat (2) @(negedge aclk);
         for (int k = 0; k < 4; k++) begin
            bus.rvalid = 1'b1; bus.rlast = (k == 3);
            @(negedge aclk);
         end
      end
      bus.rvalid = 1'b0; bus.rlast = 1'b0; bus.rready = 1'b0; enable_i = 1'b0;
      do_snap();
      rd(0,  64'd0,  "rd_idle");
      rd(1,  64'd0,  "rd_out");
      rd(2,  64'd0,  "ar_stall");
      rd(3,  64'd3,  "ar_hs");
      rd(4,  64'd8,  "rvalid_stall");
      rd(5,  64'd0,  "rready_stall");
      rd(6,  64'd12, "r_hs");
      rd(7,  64'd21, "rd_wr_idle");
      rd(18, 64'd21, "rd_cycles");
      rd(19, EXP_RD_LAT, "rd_lat_sum");
      rd(21, EXP_RD_MAX, "rd_max");
      chk("rd_perr", 64'(proto_err_o), 64'd0);

      // write with WLAST ahead of AW, B delayed with one BREADY-low cycle
      do_clear();
      enable_i = 1'b1;
      bus.wvalid = 1'b1; bus.wready = 1'b1; bus.wlast = 1'b1;
      @(negedge aclk);
      bus.wvalid = 1'b0; bus.wready = 1'b0; bus.wlast = 1'b0;
      @(negedge aclk);
      bus.awvalid = 1'b1; bus.awready = 1'b1;
      @(negedge aclk);
      bus.awvalid = 1'b0; bus.awready = 1'b0;
      repeat (2) @(negedge aclk);
      bus.bvalid = 1'b1; bus.bready = 1'b0;
      @(negedge aclk);
      bus.bready = 1'b1;
      @(negedge aclk);
      bus.bvalid = 1'b0; bus.bready = 1'b0; enable_i = 1'b0;
      chk("wr_perr", 64'(proto_err_o), 64'd0);
      do_snap();
      rd(0,  64'd7, "wr_rd_idle");
      rd(7,  64'd2, "wr_idle");
      rd(8,  64'd0, "wr_out");
      rd(9,  64'd0, "wr_resp");
      rd(10, 64'd0, "aw_stall");
      rd(11, 64'd1, "aw_hs");
      rd(12, 64'd0, "wvalid_stall");
      rd(13, 64'd0, "wready_stall");
      rd(14, 64'd1, "w_hs");
      rd(15, 64'd4, "bvalid_stall");
      rd(16, 64'd1, "bready_stall");
      rd(17, 64'd1, "b_hs");
      rd(18, 64'd7, "wr_cycles");
      rd(20, EXP_WR_LAT, "wr_lat_sum");
      rd(22, EXP_WR_MAX, "wr_max");
      rd(21, 64'd0, "wr_rd_max");

      // snap and clear together
      do_clear();
      enable_i = 1'b1;
      repeat (100) @(negedge aclk);
      snap_i = 1'b1; clear_i = 1'b1;
      @(negedge aclk);
      snap_i = 1'b0; clear_i = 1'b0; enable_i = 1'b0;
      rd(18, 64'd100, "snapclr_pre");
      enable_i = 1'b1;
      repeat (5) @(negedge aclk);
      enable_i = 1'b0;
      do_snap();
      rd(18, 64'd5, "snapclr_post");

      // R beat with RLAST while nothing is outstanding
      do_clear();
      chk("perr_clear", 64'(proto_err_o), 64'd0);
      bus.rvalid = 1'b1; bus.rready = 1'b1; bus.rlast = 1'b1;
      @(negedge aclk);
      bus.rvalid = 1'b0; bus.rready = 1'b0; bus.rlast = 1'b0;
      chk("perr_set", 64'(proto_err_o), 64'd1);
      do_snap();
      rd(1,  64'd0, "perr_rd_out");
      rd(23, 64'd4, "perr_status");

      // saturation of a 16-bit counter
      do_clear();
      enable_i = 1'b1; bus.arvalid = 1'b1; bus.arready = 1'b0;
      repeat (65534) @(negedge aclk);
      chk("ovf_below", 64'(overflow_o), 64'd0);
      @(negedge aclk);
      chk("ovf_at_max", 64'(overflow_o), 64'd1);
      repeat (70000 - 65535) @(negedge aclk);
      bus.arvalid = 1'b0; enable_i = 1'b0;
      do_snap();
      rd(2,  64'd65535, "sat_ar_stall");
      rd(18, 64'd65535, "sat_cycles");
      rd(0,  64'd0,     "sat_rd_idle");
      rd(23, 64'd2,     "sat_status");
      do_clear();
      chk("ovf_cleared", 64'(overflow_o), 64'd0);
      do_snap();
      rd(2,  64'd0, "sat_clr_ar_stall");
      rd(18, 64'd0, "sat_clr_cycles");

      repeat (3) @(negedge aclk);
      chk("q_drained", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
